// File: rtl/prog_loader_arb_pkg.sv
// Shared types and constants for the program loader / memory write arbiter.
package prog_loader_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int DEFAULT_ADDR_W = 14;

  localparam int         BYTE_W    = 8;
  localparam int         LANES     = 4;
  localparam int         WORD_W    = BYTE_W * LANES;
  localparam logic [1:0] LAST_LANE = 2'd3;

endpackage

// File: rtl/prog_loader_arb_if.sv
// Loader byte stream, CPU data-memory port and arbitrated memory port.
interface prog_loader_arb_if
  import prog_loader_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic                rx_valid;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_last;
  logic                rx_ready;

  logic                cpu_mem_we;
  logic [31:0]         cpu_mem_addr;
  logic [WORD_W-1:0]   cpu_mem_wdata;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;

  modport slave (
    input  rx_valid, rx_data, rx_last, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data, rx_last, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader_arb_word_assembler.sv
// Packs loader bytes little-endian into a 32-bit word; lanes not yet written stay zero.
module word_assembler
  import prog_loader_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [1:0]        byte_idx_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (accept_i) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTE_W-1:0] lane_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_q <= '0;
        end else if (clear_i) begin
          lane_q <= '0;
        end else if (accept_i && (idx_q == 2'(gi))) begin
          lane_q <= byte_i;
        end
      end

      assign word_o[gi*BYTE_W +: BYTE_W] = lane_q;
    end
  endgenerate

  assign byte_idx_o = idx_q;

endmodule

// File: rtl/prog_loader_arb.sv
// Serial program loader that holds the CPU in reset and owns the data-memory
// write port while an image streams in; otherwise the CPU port passes straight through.
module prog_loader_arb
  import prog_loader_arb_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              load_req,
  prog_loader_arb_if.slave  bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0]   MAX_WC    = (ADDR_W + 1)'(MAX_WORDS);

  state_e            state_q, state_d;
  logic              load_req_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              err_q, err_d;
  logic              final_q, final_d;

  logic              load_rise;
  logic              accept;
  logic              asm_clear;
  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] asm_word;
  logic [ADDR_W:0]   wc_inc;

  logic              rx_ready_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [WORD_W-1:0] mem_wdata_c;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_mem_addr[31:ADDR_W+2], bus.cpu_mem_addr[1:0]};

  assign load_rise = load_req & ~load_req_q;
  assign accept    = (state_q == ST_LOAD) & bus.rx_valid;
  assign wc_inc    = wc_q + (ADDR_W + 1)'(1);

  word_assembler u_word_assembler (
    .clk        (cpu_clk),
    .rst        (reset),
    .clear_i    (asm_clear),
    .accept_i   (accept),
    .byte_i     (bus.rx_data),
    .byte_idx_o (byte_idx),
    .word_o     (asm_word)
  );

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      load_req_q <= 1'b0;
      addr_q     <= '0;
      wc_q       <= '0;
      err_q      <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_req_q <= load_req;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      err_q      <= err_d;
      final_q    <= final_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wc_d        = wc_q;
    err_d       = err_q;
    final_d     = final_q;
    asm_clear   = 1'b0;
    rx_ready_c  = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = addr_q;
    mem_wdata_c = asm_word;
    load_done   = 1'b0;
    cpu_hold    = 1'b1;

    case (state_q)
      ST_RUN: begin
        cpu_hold    = 1'b0;
        mem_we_c    = bus.cpu_mem_we;
        mem_addr_c  = bus.cpu_mem_addr[ADDR_W+1:2];
        mem_wdata_c = bus.cpu_mem_wdata;
        if (load_rise) begin
          state_d   = ST_LOAD;
          addr_d    = '0;
          wc_d      = '0;
          err_d     = 1'b0;
          final_d   = 1'b0;
          asm_clear = 1'b1;
        end
      end

      ST_LOAD: begin
        rx_ready_c = 1'b1;
        if (accept) begin
          if ((byte_idx == LAST_LANE) || bus.rx_last) begin
            state_d = ST_WRITE;
          end
          if (bus.rx_last) begin
            final_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        mem_we_c  = 1'b1;
        wc_d      = wc_inc;
        asm_clear = 1'b1;
        // Saturate so the final permitted word never wraps back to address 0.
        if (addr_q != ADDR_LAST) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (final_q || (wc_inc == MAX_WC)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_LOAD;
        end
        if (!final_q && (wc_inc == MAX_WC)) begin
          err_d = 1'b1;
        end
      end

      ST_FINISH: begin
        load_done = 1'b1;
        state_d   = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.rx_ready  = rx_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  assign word_count    = wc_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_prog_loader_arb.sv
// Directed bench for prog_loader_arb: normal loads, partial word, overflow, reset abort, arbitration.
module tb_prog_loader_arb;
  import prog_loader_arb_pkg::*;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 4;

  logic              cpu_clk;
  logic              reset;
  logic              load_req;
  logic              cpu_hold;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_overflow;

  prog_loader_arb_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader_arb #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .load_req     (load_req),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                done_cnt = 0;

  always @(negedge cpu_clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      $display("mem write addr=%0h data=%08h", bus.mem_addr, bus.mem_wdata);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b0;
    tick();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    load_req = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_last  = last;
    #1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("rx_ready_wait", {63'd0, bus.rx_ready}, 64'd1);
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
  endtask

  logic [7:0] img1 [8];
  logic [7:0] k;
  logic       acc;

  initial begin
    img1[0] = 8'h78; img1[1] = 8'h56; img1[2] = 8'h34; img1[3] = 8'h12;
    img1[4] = 8'hEF; img1[5] = 8'hBE; img1[6] = 8'hAD; img1[7] = 8'hDE;

    reset             = 1'b1;
    load_req          = 1'b0;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = '0;
    bus.rx_last       = 1'b0;
    bus.cpu_mem_we    = 1'b0;
    bus.cpu_mem_addr  = '0;
    bus.cpu_mem_wdata = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_cpu_hold",  {63'd0, cpu_hold},      64'd0);
    chk("rst_rx_ready",  {63'd0, bus.rx_ready},  64'd0);
    chk("rst_load_done", {63'd0, load_done},     64'd0);
    chk("rst_word_count", 64'(word_count),       64'd0);
    chk("rst_err",       {63'd0, err_overflow},  64'd0);
    chk("rst_mem_we",    {63'd0, bus.mem_we},    64'd0);
    reset = 1'b0;
    tick();

    // RUN pass-through
    bus.cpu_mem_we    = 1'b1;
    bus.cpu_mem_addr  = 32'h10;
    bus.cpu_mem_wdata = 32'hCAFEF00D;
    #1;
    chk("run_mem_we",    {63'd0, bus.mem_we},     64'd1);
    chk("run_mem_addr",  64'(bus.mem_addr),       64'd4);
    chk("run_mem_wdata", 64'(bus.mem_wdata),      64'hCAFEF00D);
    bus.cpu_mem_we = 1'b0;
    tick();

    // Two-word image with CPU writes attempted throughout the load
    start_load();
    chk("ld1_cpu_hold", {63'd0, cpu_hold},     64'd1);
    chk("ld1_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
    bus.cpu_mem_we   = 1'b1;
    bus.cpu_mem_addr = 32'h20;
    #1;
    chk("ld1_cpu_we_blocked", {63'd0, bus.mem_we}, 64'd0);
    for (int i = 0; i < 8; i++) send_byte(img1[i], (i == 7));
    chk("ld1_write_we",    {63'd0, bus.mem_we}, 64'd1);
    chk("ld1_write_addr",  64'(bus.mem_addr),   64'd1);
    chk("ld1_write_data",  64'(bus.mem_wdata),  64'hDEADBEEF);
    chk("ld1_write_hold",  {63'd0, cpu_hold},   64'd1);
    chk("ld1_write_nodone", {63'd0, load_done}, 64'd0);
    bus.cpu_mem_we = 1'b0;
    tick();
    chk("ld1_finish_done", {63'd0, load_done}, 64'd1);
    chk("ld1_finish_hold", {63'd0, cpu_hold},  64'd1);
    tick();
    chk("ld1_run_hold",  {63'd0, cpu_hold},  64'd0);
    chk("ld1_run_done",  {63'd0, load_done}, 64'd0);
    chk("ld1_word_count", 64'(word_count),   64'd2);
    chk("ld1_err",       {63'd0, err_overflow}, 64'd0);
    chk("ld1_nwrites",   64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("ld1_w0_addr", 64'(wr_addr_q[0]), 64'd0);
      chk("ld1_w0_data", 64'(wr_data_q[0]), 64'h12345678);
      chk("ld1_w1_addr", 64'(wr_addr_q[1]), 64'd1);
      chk("ld1_w1_data", 64'(wr_data_q[1]), 64'hDEADBEEF);
    end
    chk("ld1_done_pulses", 64'(done_cnt), 64'd1);
    // load_req still high: no retrigger
    repeat (6) tick();
    chk("hold_no_retrig_hold", {63'd0, cpu_hold}, 64'd0);
    chk("hold_no_retrig_writes", 64'(wr_addr_q.size()), 64'd2);

    // Partial word
    start_load();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    tick();
    tick();
    chk("ld2_word_count", 64'(word_count), 64'd1);
    chk("ld2_nwrites", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() == 1) begin
      chk("ld2_w0_addr", 64'(wr_addr_q[0]), 64'd0);
      chk("ld2_w0_data", 64'(wr_data_q[0]), 64'h0000BBAA);
    end
    chk("ld2_cpu_hold", {63'd0, cpu_hold}, 64'd0);

    // Overflow: offer 20 bytes with no rx_last into a 4-word capacity
    start_load();
    k = 8'd0;
    for (int c = 0; c < 40; c++) begin
      bus.rx_valid = (k < 8'd20);
      bus.rx_data  = k;
      #1;
      acc = bus.rx_valid & bus.rx_ready;
      tick();
      if (acc) k = k + 8'd1;
    end
    bus.rx_valid = 1'b0;
    chk("ovf_accepted", 64'(k), 64'd16);
    chk("ovf_nwrites", 64'(wr_addr_q.size()), 64'd4);
    if (wr_addr_q.size() == 4) begin
      chk("ovf_w0", {32'(wr_addr_q[0]), wr_data_q[0]}, {32'd0, 32'h03020100});
      chk("ovf_w1", {32'(wr_addr_q[1]), wr_data_q[1]}, {32'd1, 32'h07060504});
      chk("ovf_w2", {32'(wr_addr_q[2]), wr_data_q[2]}, {32'd2, 32'h0B0A0908});
      chk("ovf_w3", {32'(wr_addr_q[3]), wr_data_q[3]}, {32'd3, 32'h0F0E0D0C});
    end
    chk("ovf_err",        {63'd0, err_overflow}, 64'd1);
    chk("ovf_word_count", 64'(word_count),       64'd4);
    chk("ovf_rx_ready",   {63'd0, bus.rx_ready}, 64'd0);
    chk("ovf_done_pulses", 64'(done_cnt),        64'd1);
    chk("ovf_cpu_hold",   {63'd0, cpu_hold},     64'd0);

    // Reset mid-load
    start_load();
    chk("rab_err_cleared", {63'd0, err_overflow}, 64'd0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    chk("rab_cpu_hold",   {63'd0, cpu_hold},     64'd0);
    chk("rab_rx_ready",   {63'd0, bus.rx_ready}, 64'd0);
    chk("rab_mem_we",     {63'd0, bus.mem_we},   64'd0);
    chk("rab_word_count", 64'(word_count),       64'd0);
    load_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("rab_nwrites", 64'(wr_addr_q.size()), 64'd0);
    chk("rab_hold_after", {63'd0, cpu_hold}, 64'd0);

    // Fresh rising edge restarts at address 0
    start_load();
    chk("re_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    send_byte(8'h5A, 1'b1);
    chk("re_write_addr", 64'(bus.mem_addr),  64'd0);
    chk("re_write_data", 64'(bus.mem_wdata), 64'h0000005A);
    tick();
    tick();
    chk("re_word_count", 64'(word_count), 64'd1);
    chk("re_nwrites", 64'(wr_addr_q.size()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
